div_seq_ctrl: RTL

Multi-cycle sequencer for unsigned restoring division in the ALU. It latches an M-bit dividend and divisor on a start request and produces one quotient bit per clock over M iterations. It then presents registered quotient, remainder and flags with a single-cycle completion pulse. It is the clocked counterpart of the combinational divider and lets the ALU share one subtract/compare stage across all quotient bits.

---
 rtl/div_seq_ctrl_if.sv | 8 +
 rtl/div_seq_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: operand request and result bundle of the sequential divider
interface div_seq_ctrl_if #(parameter int M = 4);
  logic start;
  logic [M-1:0] expresionA, expresionB, cociente, residuo;
  logic busy, done, carry, cero;
  modport master(output start, expresionA, expresionB, input cociente, residuo, busy, done, carry, cero);
  modport slave(input start, expresionA, expresionB, output cociente, residuo, busy, done, carry, cero);
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: restoring divider producing one quotient bit per clock, results held until the next completion
module div_seq_ctrl #(parameter int M = 4) (
  input logic clk,
  input logic rst,
  div_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(M);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, nxt;
  logic [M-1:0] dvd, dvs, q, q_nx, r, r_nx;
  logic [M:0] r_sh;
  logic [CW-1:0] cnt;
  logic ge, last, go, zdiv;
  // r stays below the divisor, so only the shifted value needs the extra bit
  always_comb begin
    go = state == IDLE && bus.start;
    zdiv = bus.expresionB == '0;
    last = cnt == '0;
    r_sh = {r, dvd[M-1]};
    ge = r_sh >= {1'b0, dvs};
    r_nx = ge ? M'(r_sh - {1'b0, dvs}) : r_sh[M-1:0];
    q_nx = {q[M-2:0], ge};
    bus.busy = state == RUN;
    bus.done = state == FIN;
    nxt = state;
    if (go) nxt = zdiv ? FIN : RUN;
    else if (state == RUN && last) nxt = FIN;
    else if (state == FIN) nxt = IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_ff @(posedge clk)
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      bus.cociente <= '0;
      bus.residuo <= '0;
      bus.carry <= 1'b0;
      bus.cero <= 1'b0;
    end else begin
      if (go && !zdiv) begin
        dvd <= bus.expresionA;
        dvs <= bus.expresionB;
        r <= '0;
        q <= '0;
        cnt <= CW'(M - 1);
      end
      if (go && zdiv) begin
        bus.cociente <= '1;
        bus.residuo <= bus.expresionA;
        bus.carry <= 1'b1;
        bus.cero <= 1'b0;
      end
      if (state == RUN) begin
        dvd <= dvd << 1;
        r <= r_nx;
        q <= q_nx;
        cnt <= cnt - 1'b1;
      end
      if (state == RUN && last) begin
        bus.cociente <= q_nx;
        bus.residuo <= r_nx;
        bus.carry <= 1'b0;
        bus.cero <= q_nx == '0;
      end
    end
endmodule
